// File: rtl/clz_pkg.sv
// Shared types and width helpers for the iterative count-leading-zeros unit.
//  - clz_state_t : FSM encoding (IDLE -> SCAN -> DONE)
//  - cnt_width() : width of a 0..XLEN count
//  - CNT_W       : count width at the default XLEN of 32
package clz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } clz_state_t;

    localparam int XLEN_DEF = 32;

    // A count of 0..xlen inclusive needs one bit more than log2(xlen).
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

    localparam int CNT_W = cnt_width(XLEN_DEF);

endpackage

// File: rtl/clz_chunk.sv
// Combinational leading-zero count of a W-bit chunk, built from per-nibble
// counts combined from the MSB nibble downwards.
// W must be a multiple of 4. The caller only uses the result for a non-zero
// chunk; an all-zero chunk yields W.
//  x   in  W              chunk to examine
//  lz  out $clog2(W)+1    number of leading zeros
module clz_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0]         x,
    output logic [$clog2(W):0]   lz
);

    localparam int NNIB = W / 4;
    localparam int OW   = $clog2(W) + 1;

    // Leading zeros of one nibble, 0..4.
    function automatic logic [2:0] nib_lz(input logic [3:0] n);
        logic [2:0] r;
        casez (n)
            4'b1???: r = 3'd0;
            4'b01??: r = 3'd1;
            4'b001?: r = 3'd2;
            4'b0001: r = 3'd3;
            default: r = 3'd4;
        endcase
        return r;
    endfunction

    logic [OW-1:0] cnt_s;
    logic          found_s;

    // Accumulate nibble counts until the first non-zero nibble is reached.
    always_comb begin
        cnt_s   = {OW{1'b0}};
        found_s = 1'b0;
        for (int i = NNIB - 1; i >= 0; i--) begin
            if (!found_s) begin
                cnt_s = cnt_s + OW'(nib_lz(x[i*4 +: 4]));
                if (x[i*4 +: 4] != 4'h0) begin
                    found_s = 1'b1;
                end else begin
                    found_s = 1'b0;
                end
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    assign lz = cnt_s;

endmodule

// File: rtl/clz_iter.sv
// Multi-cycle count-leading-zeros unit. Scans the operand CHUNK bits per cycle
// from the MSB end and stops at the first non-zero chunk; x == 0 gives XLEN.
// Valid/ready on both sides, no overlap between operations.
//  clk        in   clock, rising edge
//  rst        in   asynchronous active-high reset
//  flush      in   synchronous abort of the current operation
//  in_valid   in   operand valid
//  in_ready   out  unit idle and able to accept an operand
//  x          in   XLEN-bit operand
//  out_valid  out  result valid (registered)
//  out_ready  in   consumer accepts the result
//  res        out  leading-zero count 0..XLEN (registered)
module clz_iter
    import clz_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(XLEN):0] res
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int CNT_WL = cnt_width(XLEN);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LZ_W   = $clog2(CHUNK) + 1;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    clz_state_t        state_r;
    logic [XLEN-1:0]   shreg_r;
    logic [IDX_W-1:0]  idx_r;
    logic [CNT_WL-1:0] count_r;
    logic [CNT_WL-1:0] res_r;
    logic              out_valid_r;

    logic [CHUNK-1:0]  top_s;
    logic [LZ_W-1:0]   lz_s;
    logic [CNT_WL-1:0] add_s;
    logic [CNT_WL-1:0] sum_s;
    logic              stop_s;

    assign top_s = shreg_r[XLEN-1 -: CHUNK];

    clz_chunk #(.W(CHUNK)) u_chunk (
        .x  (top_s),
        .lz (lz_s)
    );

    // Count contribution of the chunk currently at the top of the shift register.
    always_comb begin
        add_s  = CNT_WL'(CHUNK);
        stop_s = 1'b0;
        if (top_s != {CHUNK{1'b0}}) begin
            add_s  = CNT_WL'(lz_s);
            stop_s = 1'b1;
        end else begin
            add_s  = CNT_WL'(CHUNK);
            stop_s = (idx_r == IDX_LAST);
        end
        sum_s = count_r + add_s;
    end

    // Control FSM with shift register, chunk index, accumulator and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            shreg_r     <= {XLEN{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            count_r     <= {CNT_WL{1'b0}};
            res_r       <= {CNT_WL{1'b0}};
            out_valid_r <= 1'b0;
        end else if (flush) begin
            // Flush beats any same-cycle in_valid or out_ready; result dropped.
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shreg_r <= x;
                        count_r <= {CNT_WL{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= SCAN;
                    end
                end
                SCAN: begin
                    count_r <= sum_s;
                    if (stop_s) begin
                        res_r       <= sum_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        shreg_r <= shreg_r << CHUNK;
                        idx_r   <= idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign res       = res_r;

endmodule
